// File: rtl/ext_int_gen_pkg.sv
// Shared constants, register map and FSM encoding for the external interrupt generator.
package ext_int_gen_pkg;

  localparam logic [31:0] EIG_BASE     = 32'h0000_7F30;
  localparam logic [31:0] INT_ACK_ADDR = 32'h0000_7F20;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 2;
  localparam int STAT_PEND = 0;
  localparam int STAT_OVR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CNT    = 2'd2,
    ST_EXPIRE = 2'd3
  } eig_state_e;

endpackage

// File: rtl/ext_int_gen_be_merge.sv
// Merges an old and a new 32-bit word byte by byte under a 4-bit byte enable.
module ext_int_gen_be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign merged[8*i +: 8] = byteen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/ext_int_gen.sv
// Bus-mapped countdown timer that raises a level interrupt and drops it on the CPU's ack store.
module ext_int_gen
  import ext_int_gen_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = EIG_BASE,
  parameter logic [31:0] ACK_ADDR  = INT_ACK_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  input  logic [31:0] int_addr,
  input  logic [3:0]  int_byteen,
  output logic        interrupt
);

  // Bus handshake: no valid/ready; a write is accepted on any edge where addr hits the
  // window and any byteen bit is set, reads are combinational and always accepted.

  logic        en, mode, im;
  logic        pend, ovr;
  logic [31:0] period, count;
  eig_state_e  state, state_next;

  logic        hit, wr, ack;
  logic [1:0]  off;
  logic        wr_ctrl, wr_period, wr_status;
  logic        w1c_pend, w1c_ovr;
  logic [31:0] reg_word, merged;
  logic        load_evt, dec_evt, expire_evt, oneshot_done;
  logic        unused_addr_bits;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign wr        = hit && (|byteen);
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_period = wr && (off == OFF_PERIOD);
  assign wr_status = wr && (off == OFF_STATUS);
  assign w1c_pend  = wr_status && byteen[0] && wdata[STAT_PEND];
  assign w1c_ovr   = wr_status && byteen[0] && wdata[STAT_OVR];
  assign ack       = (int_addr == ACK_ADDR) && (|int_byteen);
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    reg_word = '0;
    case (off)
      OFF_CTRL:   reg_word = {29'b0, im, mode, en};
      OFF_PERIOD: reg_word = period;
      OFF_COUNT:  reg_word = count;
      OFF_STATUS: reg_word = {30'b0, ovr, pend};
      default:    reg_word = '0;
    endcase
  end

  assign rdata = hit ? reg_word : '0;

  // One merger serves both writable registers: the old word is whatever the addressed register reads.
  ext_int_gen_be_merge u_be_merge (
    .old_word (reg_word),
    .new_word (wdata),
    .byteen   (byteen),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (period != '0) state_next = ST_LOAD;
        ST_LOAD:   state_next = ST_CNT;
        ST_CNT:    if (count <= 32'd1) state_next = ST_EXPIRE;
        ST_EXPIRE: state_next = mode ? ST_LOAD : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Every action is gated by EN so a disable freezes COUNT on the very edge it is seen.
  always_comb begin
    load_evt     = (state == ST_LOAD) && en;
    dec_evt      = (state == ST_CNT) && en;
    expire_evt   = dec_evt && (count <= 32'd1);
    oneshot_done = (state == ST_EXPIRE) && en && !mode;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en   <= 1'b0;
      mode <= 1'b0;
      im   <= 1'b0;
    end else begin
      if (oneshot_done) en <= 1'b0;
      if (wr_ctrl) begin
        en   <= merged[CTRL_EN];
        mode <= merged[CTRL_MODE];
        im   <= merged[CTRL_IM];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)         period <= '0;
    else if (wr_period) period <= merged;
  end

  always_ff @(posedge clk) begin
    if (!reset)        count <= '0;
    else if (load_evt) count <= period;
    else if (dec_evt)  count <= (count <= 32'd1) ? 32'd0 : count - 32'd1;
  end

  // Expiry beats any clear; an ack landing with an expiry counts as servicing, not overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (expire_evt)           pend <= 1'b1;
      else if (ack || w1c_pend) pend <= 1'b0;
      if (expire_evt && pend && !ack) ovr <= 1'b1;
      else if (w1c_ovr)               ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) interrupt <= 1'b0;
    else        interrupt <= pend & im;
  end

endmodule

// File: tb/tb_ext_int_gen.sv
// Self-checking bench for ext_int_gen: per-feature tasks with an expected-value queue.
module tb_ext_int_gen;

  localparam logic [31:0] BASE = 32'h0000_7F30;
  localparam logic [31:0] ACK  = 32'h0000_7F20;
  localparam logic [1:0]  R_CTRL = 2'd0, R_PERIOD = 2'd1, R_COUNT = 2'd2, R_STATUS = 2'd3;

  logic        clk, reset;
  logic [31:0] addr, wdata, rdata, int_addr;
  logic [3:0]  byteen, int_byteen;
  logic        interrupt;

  logic [31:0] exp_q[$];
  int          n_tests, n_fail;

  ext_int_gen dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .byteen     (byteen),
    .rdata      (rdata),
    .int_addr   (int_addr),
    .int_byteen (int_byteen),
    .interrupt  (interrupt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // drivers: all activity happens at the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
    addr   = BASE + {28'b0, off, 2'b00};
    wdata  = data;
    byteen = be;
    @(negedge clk);
    byteen = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    addr = BASE + {28'b0, off, 2'b00};
    #1;
    data = rdata;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    step(cycles);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    do_reset(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(i[1:0], got);
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h required %h", i, got, exp);
      end
    end
    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b required 0", interrupt);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] got, exp, obs;
    bus_write(R_PERIOD, 32'd5, 4'hF);
    bus_write(R_CTRL, 32'h5, 4'hF);
    // {interrupt, ovr, pend} after each edge: LOAD at edge 2, PEND at 7, interrupt at 8
    for (int c = 1; c <= 8; c++) exp_q.push_back({29'b0, (c >= 8), 1'b0, (c >= 7)});
    for (int c = 1; c <= 8; c++) begin
      step(1);
      bus_read(R_STATUS, got);
      obs = {29'b0, interrupt, got[1:0]};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL oneshot_cycle%0d: got %h required %h", c, obs, exp);
      end
    end
    exp_q.push_back(32'h4);
    bus_read(R_CTRL, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL oneshot_ctrl_en_cleared: got %h required %h", got, exp);
    end
    int_addr   = ACK;
    int_byteen = 4'hF;
    step(1);
    int_byteen = 4'h0;
    int_addr   = 32'h0;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    n_tests++;
    exp = exp_q.pop_front();
    if ({31'b0, interrupt} !== exp) begin
      n_fail++;
      $display("FAIL ack_edge1_irq: got %b required %h", interrupt, exp);
    end
    step(1);
    n_tests++;
    exp = exp_q.pop_front();
    if ({31'b0, interrupt} !== exp) begin
      n_fail++;
      $display("FAIL ack_edge2_irq: got %b required %h", interrupt, exp);
    end
  endtask

  task automatic test_periodic_ovr;
    logic [31:0] got, exp, obs;
    bus_write(R_PERIOD, 32'd3, 4'hF);
    bus_write(R_CTRL, 32'h7, 4'hF);
    // expiries at edges 5 and 10; the second one finds PEND set
    for (int c = 1; c <= 10; c++) exp_q.push_back({29'b0, (c >= 6), (c >= 10), (c >= 5)});
    for (int c = 1; c <= 10; c++) begin
      step(1);
      bus_read(R_STATUS, got);
      obs = {29'b0, interrupt, got[1:0]};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL periodic_cycle%0d: got %h required %h", c, obs, exp);
      end
    end
    bus_write(R_CTRL, 32'h4, 4'hF);
    bus_write(R_STATUS, 32'h3, 4'h1);
    exp_q.push_back(32'h0);
    bus_read(R_STATUS, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL w1c_status: got %h required %h", got, exp);
    end
    step(1);
    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq_drop: got %b required 0", interrupt);
    end
  endtask

  task automatic test_ack_race;
    logic [31:0] got, exp;
    int          waited;
    bus_write(R_PERIOD, 32'd2, 4'hF);
    bus_write(R_CTRL, 32'h7, 4'hF);
    waited = 0;
    while (interrupt !== 1'b1 && waited < 50) begin
      step(1);
      waited++;
    end
    bus_read(R_COUNT, got);
    while (got !== 32'd1 && waited < 80) begin
      step(1);
      waited++;
      bus_read(R_COUNT, got);
    end
    n_tests++;
    if (waited >= 80 || interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_race_setup: got irq=%b count=%h required irq=1 count=1", interrupt, got);
      bus_write(R_CTRL, 32'h0, 4'hF);
      return;
    end
    // COUNT==1 in CNT: the coming edge is an expiry; ack it in the same cycle
    int_addr   = ACK;
    int_byteen = 4'hF;
    step(1);
    int_byteen = 4'h0;
    int_addr   = 32'h0;
    exp_q.push_back(32'h1);
    bus_read(R_STATUS, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL ack_race_status: got %h required %h", got, exp);
    end
    for (int c = 0; c < 4; c++) exp_q.push_back(32'h1);
    for (int c = 0; c < 4; c++) begin
      exp = exp_q.pop_front();
      n_tests++;
      if ({31'b0, interrupt} !== exp) begin
        n_fail++;
        $display("FAIL ack_race_irq%0d: got %b required %h", c, interrupt, exp);
      end
      if (c < 3) step(1);
    end
    bus_write(R_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_byteen;
    logic [31:0] got, exp;
    do_reset(1);
    bus_write(R_CTRL, 32'h1, 4'hF);
    step(4);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_read(R_COUNT, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL zero_period_count: got %h required %h", got, exp);
    end
    bus_read(R_STATUS, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL zero_period_status: got %h required %h", got, exp);
    end
    bus_write(R_CTRL, 32'hFFFF_FFF8, 4'hF);
    bus_write(R_PERIOD, 32'h1122_3344, 4'hF);
    bus_write(R_PERIOD, 32'hAABB_CCDD, 4'b0001);
    bus_write(R_COUNT, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1122_33DD);
    exp_q.push_back(32'h0);
    bus_read(R_CTRL, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL ctrl_reserved_bits: got %h required %h", got, exp);
    end
    bus_read(R_PERIOD, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL period_byteen: got %h required %h", got, exp);
    end
    bus_read(R_COUNT, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL count_read_only: got %h required %h", got, exp);
    end
    addr = BASE + 32'h14;
    #1;
    n_tests++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL miss_window: got %h required 00000000", rdata);
    end
    // disable mid-count: COUNT must freeze at 0x10 - 5 = 0x0B
    bus_write(R_PERIOD, 32'h10, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    step(6);
    bus_write(R_CTRL, 32'h0, 4'hF);
    step(3);
    exp_q.push_back(32'h0B);
    bus_read(R_COUNT, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL disable_freeze: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] got, exp;
    int          waited;
    bus_write(R_PERIOD, 32'h50, 4'hF);
    bus_write(R_CTRL, 32'h7, 4'hF);
    waited = 0;
    bus_read(R_COUNT, got);
    while (got !== 32'h40 && waited < 100) begin
      step(1);
      waited++;
      bus_read(R_COUNT, got);
    end
    n_tests++;
    if (got !== 32'h40) begin
      n_fail++;
      $display("FAIL midcount_setup: got %h required 00000040", got);
    end
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(i[1:0], got);
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midreset_reg%0d: got %h required %h", i, got, exp);
      end
    end
    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_irq: got %b required 0", interrupt);
    end
    reset = 1'b1;
    step(4);
    exp_q.push_back(32'h0);
    bus_read(R_COUNT, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h required %h", got, exp);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;
    byteen     = 4'h0;
    int_addr   = 32'h0;
    int_byteen = 4'h0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic_ovr();
    test_ack_race();
    test_byteen();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
